// File: rtl/sp_load_store_arbiter_if.sv
// ---------------------------------------------------------------------------
// sp_load_store_arbiter_if
//
// Bundles the scratchpad-side burst request signals and the backing-memory
// port of sp_load_store_arbiter.
//
// Signals
//   sLoad / load_addr          level load request and byte base address
//   sStore / store_addr        level store request and byte base address
//   store_data                 current store row (advanced after sStore_hit)
//   load_data                  registered load row data
//   sLoad_hit / sLoad_row      one-cycle pulse: load_data valid for that row
//   sStore_hit                 one-cycle pulse: current store row written
//   mem_req / mem_wen          memory request, 1 = write
//   mem_addr / mem_wdata       row byte address and write data
//   mem_rdata / mem_ready      read data and request completion
//
// Handshake: mem_req is a valid that stays high, with mem_wen/mem_addr/
// mem_wdata stable, until a rising clock edge where mem_ready is also high;
// that edge completes the transfer and mem_rdata is taken on it. mem_ready
// is ignored while mem_req is low. Only one request is outstanding at a time.
//
// Modports
//   slave  : the arbiter itself
//   master : the environment (scratchpad plus memory)
// ---------------------------------------------------------------------------
interface sp_load_store_arbiter_if #(
    parameter int WORD_W       = 32,
    parameter int BITS_PER_ROW = 64,
    parameter int ROW_S_W      = 2
);
    logic                    sLoad;
    logic [WORD_W-1:0]       load_addr;
    logic                    sStore;
    logic [WORD_W-1:0]       store_addr;
    logic [BITS_PER_ROW-1:0] store_data;
    logic [BITS_PER_ROW-1:0] load_data;
    logic                    sLoad_hit;
    logic [ROW_S_W-1:0]      sLoad_row;
    logic                    sStore_hit;
    logic                    mem_req;
    logic                    mem_wen;
    logic [WORD_W-1:0]       mem_addr;
    logic [BITS_PER_ROW-1:0] mem_wdata;
    logic [BITS_PER_ROW-1:0] mem_rdata;
    logic                    mem_ready;

    modport slave (
        input  sLoad, load_addr, sStore, store_addr, store_data,
        input  mem_rdata, mem_ready,
        output load_data, sLoad_hit, sLoad_row, sStore_hit,
        output mem_req, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output sLoad, load_addr, sStore, store_addr, store_data,
        output mem_rdata, mem_ready,
        input  load_data, sLoad_hit, sLoad_row, sStore_hit,
        input  mem_req, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sp_load_store_arbiter.sv
// ---------------------------------------------------------------------------
// sp_load_store_arbiter
//
// Memory-side responder for the scratchpad load/store port. A granted load
// or store request moves one matrix of ROWS = 2**ROW_S_W rows over a
// single-outstanding memory port, one row per memory transfer. Loads return
// each row with sLoad_hit/sLoad_row; stores acknowledge each row with
// sStore_hit. Contended grants alternate between load and store.
//
// Ports
//   CLK        clock
//   nRST       asynchronous active-low reset
//   bus        sp_load_store_arbiter_if.slave (scratchpad + memory signals)
//   dbg_state  current FSM state encoding (IDLE=0 LD_REQ=1 LD_RESP=2
//              ST_REQ=3 ST_RESP=4 WAIT_DROP=5)
// ---------------------------------------------------------------------------
module sp_load_store_arbiter #(
    parameter int WORD_W       = 32,
    parameter int BITS_PER_ROW = 64,
    parameter int ROW_S_W      = 2
) (
    input  logic                          CLK,
    input  logic                          nRST,
    sp_load_store_arbiter_if.slave        bus,
    output logic [2:0]                    dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LD_REQ    = 3'd1,
        LD_RESP   = 3'd2,
        ST_REQ    = 3'd3,
        ST_RESP   = 3'd4,
        WAIT_DROP = 3'd5
    } state_t;

    localparam logic [WORD_W-1:0]  ROW_BYTES = WORD_W'(BITS_PER_ROW / 8);
    localparam logic [ROW_S_W-1:0] ROW_LAST  = '1;
    localparam logic [ROW_S_W-1:0] ROW_ONE   = ROW_S_W'(1);

    state_t                  state;
    logic [ROW_S_W-1:0]      row;
    logic [WORD_W-1:0]       base;
    logic                    last_grant;   // 0 = load, 1 = store
    logic                    any_grant;    // a grant has happened since reset

    logic                    mem_req_q;
    logic                    mem_wen_q;
    logic [WORD_W-1:0]       mem_addr_q;
    logic [BITS_PER_ROW-1:0] load_data_q;
    logic                    ld_hit_q;
    logic [ROW_S_W-1:0]      ld_row_q;
    logic                    st_hit_q;

    logic                    grant_ld;
    logic                    grant_st;
    logic                    granted_req;

    // Row byte address, wrapping modulo 2**WORD_W.
    function automatic logic [WORD_W-1:0] row_addr(
        input logic [WORD_W-1:0]  b,
        input logic [ROW_S_W-1:0] r
    );
        return b + WORD_W'(r) * ROW_BYTES;
    endfunction

    // Contended grants go to the type not served last. Out of reset no grant
    // has been made yet, so the first contended grant goes to load.
    always_comb begin
        grant_ld = 1'b0;
        grant_st = 1'b0;
        if (bus.sLoad && bus.sStore) begin
            if (!any_grant || last_grant) begin
                grant_ld = 1'b1;
            end else begin
                grant_st = 1'b1;
            end
        end else if (bus.sLoad) begin
            grant_ld = 1'b1;
        end else if (bus.sStore) begin
            grant_st = 1'b1;
        end
    end

    // Level of the request that owns the burst just finished.
    assign granted_req = last_grant ? bus.sStore : bus.sLoad;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            row         <= '0;
            base        <= '0;
            last_grant  <= 1'b0;
            any_grant   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            load_data_q <= '0;
            ld_hit_q    <= 1'b0;
            ld_row_q    <= '0;
            st_hit_q    <= 1'b0;
        end else begin
            ld_hit_q <= 1'b0;
            st_hit_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ld) begin
                        base       <= bus.load_addr;
                        row        <= '0;
                        last_grant <= 1'b0;
                        any_grant  <= 1'b1;
                        mem_req_q  <= 1'b1;
                        mem_wen_q  <= 1'b0;
                        mem_addr_q <= bus.load_addr;
                        state      <= LD_REQ;
                    end else if (grant_st) begin
                        base       <= bus.store_addr;
                        row        <= '0;
                        last_grant <= 1'b1;
                        any_grant  <= 1'b1;
                        mem_req_q  <= 1'b1;
                        mem_wen_q  <= 1'b1;
                        mem_addr_q <= bus.store_addr;
                        state      <= ST_REQ;
                    end
                end

                LD_REQ: begin
                    if (bus.mem_ready) begin
                        load_data_q <= bus.mem_rdata;
                        mem_req_q   <= 1'b0;
                        ld_hit_q    <= 1'b1;
                        ld_row_q    <= row;
                        state       <= LD_RESP;
                    end
                end

                LD_RESP: begin
                    if (row == ROW_LAST) begin
                        state <= WAIT_DROP;
                    end else begin
                        row        <= row + ROW_ONE;
                        mem_req_q  <= 1'b1;
                        mem_wen_q  <= 1'b0;
                        mem_addr_q <= row_addr(base, row + ROW_ONE);
                        state      <= LD_REQ;
                    end
                end

                ST_REQ: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_wen_q <= 1'b0;
                        st_hit_q  <= 1'b1;
                        state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (row == ROW_LAST) begin
                        state <= WAIT_DROP;
                    end else begin
                        row        <= row + ROW_ONE;
                        mem_req_q  <= 1'b1;
                        mem_wen_q  <= 1'b1;
                        mem_addr_q <= row_addr(base, row + ROW_ONE);
                        state      <= ST_REQ;
                    end
                end

                WAIT_DROP: begin
                    // Hold off until the scratchpad drops the request it was
                    // served, so the same request is not granted twice.
                    if (!granted_req) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_wen    = mem_wen_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.load_data  = load_data_q;
    assign bus.sLoad_hit  = ld_hit_q;
    assign bus.sLoad_row  = ld_row_q;
    assign bus.sStore_hit = st_hit_q;

    // Write data is passed straight through: the scratchpad advances
    // store_data on the edge that ends the hit cycle, so a registered copy
    // would lag by one row.
    assign bus.mem_wdata = (state == ST_REQ) ? bus.store_data : '0;

    assign dbg_state = state;

endmodule
